// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one adder between two lanes
// Result lands in a single-entry output register with its own valid/ready handshake.
module adder_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  input  logic             res_ready,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             accept_en, grant0, grant1, accept, both_valid;
  logic [WIDTH-1:0] op_a, op_b, sum;
  logic [TAG_W-1:0] op_tag;

  // rst_n gates accept_en so the readies are low for the whole reset window
  always_comb begin
    accept_en  = rst_n & ((state_q == EMPTY) | res_ready);
    both_valid = req0_valid & req1_valid;
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = accept_en & grant0;
    req1_ready = accept_en & grant1;
    accept     = req0_ready | req1_ready;
    op_a       = grant1 ? req1_a   : req0_a;
    op_b       = grant1 ? req1_b   : req0_b;
    op_tag     = grant1 ? req1_tag : req0_tag;
    sum        = op_a + op_b;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (res_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign res_valid = (state_q == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data     <= '0;
      res_tag      <= '0;
      res_src      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      res_data     <= sum;
      res_tag      <= op_tag;
      res_src      <= grant1;
      last_grant_q <= grant1;
    end
  end

  // Contention only counts when the loser could otherwise have been accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (both_valid && accept_en && conflict_cnt != CNT_MAX)
      conflict_cnt <= conflict_cnt + 1'b1;
  end

endmodule
